// File: rtl/d_pkg.sv
// Shared types and defaults for the serial deserializer slice.
// No logic; imported by the interface, the flop, the holding register and the top.
// No flow control here.
package d_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } deser_state_t;

  localparam int D_WORD_W_DEFAULT = 8;

endpackage

// File: rtl/d_deser_if.sv
// Bundle between the upstream bit flop, the deserializer and its word consumer.
// Pure wiring, no latency.
// Output side is valid/ready; the serial side has no back-pressure.
interface d_inter import d_pkg::*; #(
  parameter int WIDTH = D_WORD_W_DEFAULT
) ();

  localparam int CW = $clog2(WIDTH + 1);

  // serial side: d feeds the flop, q is the registered bit the deserializer samples
  logic             d;
  logic             q;
  logic             d_valid;
  logic             frame_start;

  // word side
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [CW-1:0]    bit_cnt;
  logic             overflow;

  // upstream bit flop
  modport ff (
    input  d,
    output q
  );

  // producer of the stream and consumer of words
  modport master (
    output d, d_valid, frame_start, word_ready,
    input  q, word_out, word_valid, bit_cnt, overflow
  );

  // deserializer
  modport slave (
    input  q, d_valid, frame_start, word_ready,
    output word_out, word_valid, bit_cnt, overflow
  );

endinterface

// File: rtl/d_ff.sv
// Single D flop that registers the serial bit before the deserializer.
// Latency: one clk edge from d to q.
// No back-pressure; samples every cycle.
module d_ff import d_pkg::*; (
  input  logic clk,
  input  logic reset,
  d_inter.ff   bus
);

  logic q_q;

  // register the incoming serial bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= bus.d;
  end

  assign bus.q = q_q;

endmodule

// File: rtl/d_hold_reg.sv
// One-entry valid/ready holding register for completed words.
// Latency: load is visible on the edge it is sampled; valid never depends on ready combinationally.
// A load while full and not consumed is refused and reported on drop.
module d_hold_reg import d_pkg::*; #(
  parameter int WIDTH = D_WORD_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic             drop
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             consume;
  logic             accept;

  assign consume = valid_q & ready;
  // a new word fits when the slot is empty or being drained this very cycle
  assign accept  = load & (~valid_q | consume);

  // next-state for the slot: load beats drain, so load+consume keeps valid high
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = data;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  // slot registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;
  assign drop  = load & ~accept;

endmodule

// File: rtl/d_deser.sv
// Serial-to-parallel deserializer: assembles WIDTH-bit words from the registered bit stream.
// Latency: word is valid on the same edge that samples its last bit.
// Words completed while the holding slot is full and unconsumed are dropped and flag sticky overflow.
module d_deser import d_pkg::*; #(
  parameter int WIDTH     = D_WORD_W_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  d_inter.slave  bus
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  deser_state_t     state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_word;
  logic             done;
  logic             hold_vld;
  logic [WIDTH-1:0] hold_dat;
  logic             hold_drop;

  // shift register after taking the current bit, and the value a fresh word starts from
  assign shifted    = MSB_FIRST ? {shreg_q[WIDTH-2:0], bus.q} : {bus.q, shreg_q[WIDTH-1:1]};
  assign first_word = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.q} : {bus.q, {(WIDTH-1){1'b0}}};

  // FSM next-state plus shift/count datapath; frame_start always restarts the word
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          state_d = SHIFT;
          shreg_d = bus.d_valid ? first_word : '0;
          cnt_d   = bus.d_valid ? CW'(1) : '0;
        end
      end
      SHIFT: begin
        if (bus.frame_start) begin
          // resync wins over a coinciding final bit: no completion
          shreg_d = bus.d_valid ? first_word : '0;
          cnt_d   = bus.d_valid ? CW'(1) : '0;
        end else if (bus.d_valid) begin
          if (cnt_q == LAST) begin
            done    = 1'b1;
            shreg_d = '0;
            cnt_d   = '0;
          end else begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // sticky overflow: only reset clears it
  always_comb begin
    overflow_d = overflow_q | hold_drop;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // datapath and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q    <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  d_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (done),
    .data  (shifted),
    .ready (bus.word_ready),
    .valid (hold_vld),
    .q     (hold_dat),
    .drop  (hold_drop)
  );

  assign bus.word_out   = hold_dat;
  assign bus.word_valid = hold_vld;
  assign bus.bit_cnt    = cnt_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_d_deser.sv
// Directed bench: d_ff feeding two deserializers (MSB-first and LSB-first) from one stream.
// Each bit is placed on d one cycle before it is qualified, matching the flop delay.
// Outputs are sampled 1 time unit after the rising edge.
module tb_d_deser;
  import d_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   maxcnt;

  d_inter #(.WIDTH(8)) if_m ();
  d_inter #(.WIDTH(8)) if_l ();

  d_ff u_ff_m (.clk(clk), .reset(reset), .bus(if_m));
  d_ff u_ff_l (.clk(clk), .reset(reset), .bus(if_l));

  d_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (.clk(clk), .reset(reset), .bus(if_m));
  d_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (.clk(clk), .reset(reset), .bus(if_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic dn, input logic vld, input logic fs, input logic rdy);
    if_m.d = dn; if_m.d_valid = vld; if_m.frame_start = fs; if_m.word_ready = rdy;
    if_l.d = dn; if_l.d_valid = vld; if_l.frame_start = fs; if_l.word_ready = rdy;
  endtask

  // one clock: drive at the falling edge, sample just after the rising edge
  task automatic step(input logic dn, input logic vld, input logic fs, input logic rdy);
    @(negedge clk);
    drive(dn, vld, fs, rdy);
    @(posedge clk);
    #1;
    if (int'(if_m.bit_cnt) > maxcnt) maxcnt = int'(if_m.bit_cnt);
  endtask

  // send the n low bits of val, oldest bit first (val[n-1]); fs on the first bit, gap idle cycles between bits
  task automatic send(input logic [31:0] val, input int n, input logic fs, input int gap, input logic rdy);
    logic nb;
    step(val[n-1], 1'b0, 1'b0, rdy);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          step(val[n-1-i], 1'b0, 1'b0, rdy);
          check("gap_cnt_hold", 32'(if_m.bit_cnt), i);
        end
      end
      nb = (i < n - 1) ? val[n-2-i] : 1'b0;
      step(nb, 1'b1, fs && (i == 0), rdy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    maxcnt = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_word_out", 32'(if_m.word_out), 0);
    check("rst_word_valid", 32'(if_m.word_valid), 0);
    check("rst_bit_cnt", 32'(if_m.bit_cnt), 0);
    check("rst_overflow", 32'(if_m.overflow), 0);
    @(negedge clk);
    reset = 1'b0;

    // basic word, both bit orders (A5 is a bit palindrome)
    send(32'hA5, 8, 1'b1, 0, 1'b1);
    check("basic_msb_word", 32'(if_m.word_out), 32'hA5);
    check("basic_msb_valid", 32'(if_m.word_valid), 1);
    check("basic_overflow", 32'(if_m.overflow), 0);
    check("basic_cnt_wrap", 32'(if_m.bit_cnt), 0);
    check("basic_lsb_word", 32'(if_l.word_out), 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("basic_valid_one_cycle", 32'(if_m.word_valid), 0);

    // back-to-back word without resync: 1 then seven 0s
    send(32'h80, 8, 1'b0, 0, 1'b1);
    check("order_lsb_word", 32'(if_l.word_out), 32'h01);
    check("order_msb_word", 32'(if_m.word_out), 32'h80);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // gaps of 3 idle cycles between bits
    maxcnt = 0;
    send(32'hA5, 8, 1'b1, 3, 1'b1);
    check("gap_word", 32'(if_m.word_out), 32'hA5);
    check("gap_valid", 32'(if_m.word_valid), 1);
    check("gap_cnt_max", maxcnt, 7);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // back-pressure: second word dropped, first held
    send(32'h3C, 8, 1'b0, 0, 1'b0);
    check("bp_first_word", 32'(if_m.word_out), 32'h3C);
    check("bp_first_ovf", 32'(if_m.overflow), 0);
    send(32'hF0, 8, 1'b0, 0, 1'b0);
    check("bp_held_word", 32'(if_m.word_out), 32'h3C);
    check("bp_held_valid", 32'(if_m.word_valid), 1);
    check("bp_overflow", 32'(if_m.overflow), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_drain", 32'(if_m.word_valid), 0);

    // resync after 5 bits, then 8'h81 split around a check
    send(32'h16, 5, 1'b0, 0, 1'b1);
    check("rs_partial_cnt", 32'(if_m.bit_cnt), 5);
    send(32'h4, 3, 1'b1, 0, 1'b1);
    check("rs_restart_cnt", 32'(if_m.bit_cnt), 3);
    check("rs_no_word", 32'(if_m.word_valid), 0);
    send(32'h01, 5, 1'b0, 0, 1'b1);
    check("rs_word", 32'(if_m.word_out), 32'h81);
    check("rs_valid", 32'(if_m.word_valid), 1);
    check("rs_ovf_sticky", 32'(if_m.overflow), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // frame_start on the would-be 8th bit: no completion
    send(32'h00, 7, 1'b1, 0, 1'b1);
    check("fs8_cnt7", 32'(if_m.bit_cnt), 7);
    send(32'h01, 1, 1'b1, 0, 1'b1);
    check("fs8_no_word", 32'(if_m.word_valid), 0);
    check("fs8_cnt1", 32'(if_m.bit_cnt), 1);
    check("fs8_word_kept", 32'(if_m.word_out), 32'h81);

    // async reset mid-word with a word pending
    send(32'h5A, 8, 1'b1, 0, 1'b0);
    check("ar_pending_word", 32'(if_m.word_out), 32'h5A);
    send(32'h5, 3, 1'b0, 0, 1'b0);
    check("ar_mid_cnt", 32'(if_m.bit_cnt), 3);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("ar_word_out", 32'(if_m.word_out), 0);
    check("ar_word_valid", 32'(if_m.word_valid), 0);
    check("ar_bit_cnt", 32'(if_m.bit_cnt), 0);
    check("ar_overflow", 32'(if_m.overflow), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h36, 8, 1'b1, 0, 1'b1);
    check("ar_after_msb", 32'(if_m.word_out), 32'h36);
    check("ar_after_lsb", 32'(if_l.word_out), 32'h6C);
    check("ar_after_valid", 32'(if_m.word_valid), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
